mult32x32_req_if: RTL and testbench



---
 rtl/mult32x32_pkg.sv | 17 +
 rtl/mult32x32_wdog.sv | 30 +++
 rtl/mult32x32_req_if.sv | 107 ++++++++++
 tb/tb_mult32x32_req_if.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult32x32_pkg.sv
// Shared types and sizing for the 32x32 multiplier request/response front end.
package mult32x32_pkg;

  localparam int OP_W           = 32;
  localparam int PROD_W         = 64;
  localparam int WAIT_LIMIT_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    RUN,
    SETTLE,
    RESP
  } req_if_state_t;

endpackage

// File: rtl/mult32x32_wdog.sv
// Clearable saturating counter; expired flags that the count has reached WAIT_LIMIT-1.
module mult32x32_wdog #(
  parameter int WAIT_LIMIT = 8,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mult32x32_req_if.sv
// Valid/ready front end for the sequential 32x32 multiplier core.
// Optional MULT_IF_ZERO_BYPASS_EN: zero operands answer directly without starting the core.
module mult32x32_req_if
  import mult32x32_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_a,
  input  logic [OP_W-1:0]   req_b,
  output logic              start,
  output logic [OP_W-1:0]   a,
  output logic [OP_W-1:0]   b,
  input  logic              busy,
  input  logic [PROD_W-1:0] product,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [PROD_W-1:0] resp_product,
  output logic              resp_err
);

  req_if_state_t state;
  logic          accept;
  logic          wd_expired;

  // Ready never looks at req_valid, so the requester can't form a combinational loop through us.
  assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
  assign accept    = req_valid && req_ready;

  mult32x32_wdog #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == START),
    .inc     ((state == WAIT_BUSY) && !busy),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      start        <= 1'b0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      a            <= '0;
      b            <= '0;
      resp_product <= '0;
    end else begin
      start <= 1'b0;
      if (accept) begin
        // Covers both a fresh request from IDLE and a back-to-back one during the RESP handshake.
        a          <= req_a;
        b          <= req_b;
        resp_valid <= 1'b0;
`ifdef MULT_IF_ZERO_BYPASS_EN
        if ((req_a == '0) || (req_b == '0)) begin
          state        <= RESP;
          resp_valid   <= 1'b1;
          resp_product <= '0;
          resp_err     <= 1'b0;
        end else
`endif
        begin
          state <= START;
          start <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: state <= IDLE;
          START: state <= WAIT_BUSY;
          WAIT_BUSY: begin
            if (busy) begin
              state <= RUN;
            end else if (wd_expired) begin
              state        <= RESP;
              resp_valid   <= 1'b1;
              resp_err     <= 1'b1;
              resp_product <= '0;
            end
          end
          // The core finishes accumulating during the first busy-low cycle; SETTLE samples after it.
          RUN: if (!busy) state <= SETTLE;
          SETTLE: begin
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_product <= product;
            resp_err     <= 1'b0;
          end
          RESP: begin
            if (resp_ready) begin
              state      <= IDLE;
              resp_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult32x32_req_if.sv
// Directed bench for mult32x32_req_if with a behavioural multiplier core model.
module tb_mult32x32_req_if;

  localparam int LIM = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [63:0] product;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_product;
  logic        resp_err;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  bit core_en = 1'b1;

  mult32x32_req_if dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .start        (start),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .product      (product),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  // Core model: busy high 7 cycles starting the cycle after start, product updated after the busy-low cycle.
  logic [3:0] core_cnt;
  logic       core_fin;
  always @(posedge clk) begin
    if (!reset) begin
      busy     <= 1'b0;
      core_cnt <= '0;
      core_fin <= 1'b0;
      product  <= '0;
    end else begin
      core_fin <= 1'b0;
      if (busy) begin
        if (core_cnt == 4'd1) begin
          busy     <= 1'b0;
          core_fin <= 1'b1;
        end
        core_cnt <= core_cnt - 4'd1;
      end else if (start && core_en) begin
        busy     <= 1'b1;
        core_cnt <= 4'd7;
      end
      if (core_fin) product <= {32'b0, a} * {32'b0, b};
    end
  end

  always @(posedge clk) if (start) start_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: sim time exceeded, required finish before 1000000");
    $fatal(1, "timeout");
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    req_valid = 1'b1;
    req_a     = x;
    req_b     = y;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // lat counts cycles from the request cycle; it is 1 right after the accepting edge.
  task automatic wait_resp(input int lat0, output int lat, output bit saw_ready, output bit a_moved);
    logic [31:0] a0;
    a0 = a;
    lat = lat0;
    saw_ready = 1'b0;
    a_moved = 1'b0;
    while (!resp_valid && lat < LIM) begin
      if (req_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      if (a !== a0) a_moved = 1'b1;
      lat++;
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++; if ({start, resp_valid, resp_err} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: got %b want 000", {start, resp_valid, resp_err}); end
    total++; if ({a, b, resp_product} !== 128'b0) begin bad++; $display("FAIL reset_data: got a=%h b=%h p=%h want 0", a, b, resp_product); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; bit sr; bit am; int s0;
    s0 = start_cnt;
    issue(32'h3, 32'h5);
    wait_resp(1, lat, sr, am);
    total++; if (lat !== 11) begin bad++; $display("FAIL basic_latency: got %0d want 11", lat); end
    total++; if (resp_product !== 64'h0F) begin bad++; $display("FAIL basic_product: got %h want f", resp_product); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", resp_err); end
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL basic_start_pulses: got %0d want 1", start_cnt - s0); end
    total++; if (sr !== 1'b0) begin bad++; $display("FAIL basic_busy_ready: req_ready seen %b want 0", sr); end
    total++; if (am !== 1'b0 || a !== 32'h3 || b !== 32'h5) begin bad++; $display("FAIL basic_operands: a=%h b=%h moved=%b want 3 5 0", a, b, am); end
    handshake();
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL basic_release: valid=%b ready=%b want 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_large();
    int lat; bit sr; bit am;
    resp_ready = 1'b1;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp(1, lat, sr, am);
    total++; if (lat !== 11) begin bad++; $display("FAIL large_latency: got %0d want 11", lat); end
    total++; if (resp_product !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL large_product: got %h want fffffffe00000001", resp_product); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL large_consumed: valid=%b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    int lat; bit sr; bit am;
    issue(32'h6, 32'h7);
    wait_resp(1, lat, sr, am);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b1 || resp_product !== 64'h2A) begin
        bad++; $display("FAIL stall_hold_%0d: valid=%b p=%h want 1 2a", i, resp_valid, resp_product);
      end
    end
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_a      = 32'h10;
    req_b      = 32'h10;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_req_ready: got %b want 1", req_ready); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    total++; if (start !== 1'b1 || resp_valid !== 1'b0 || a !== 32'h10) begin bad++; $display("FAIL b2b_start: start=%b valid=%b a=%h want 1 0 10", start, resp_valid, a); end
    wait_resp(1, lat, sr, am);
    total++; if (lat !== 11 || resp_product !== 64'h100) begin bad++; $display("FAIL b2b_result: lat=%0d p=%h want 11 100", lat, resp_product); end
    handshake();
  endtask

  task automatic test_watchdog();
    int lat; bit sr; bit am;
    core_en = 1'b0;
    issue(32'h2, 32'h3);
    wait_resp(1, lat, sr, am);
    total++; if (lat !== 10) begin bad++; $display("FAIL wdog_latency: got %0d want 10", lat); end
    total++; if (resp_err !== 1'b1 || resp_product !== 64'h0) begin bad++; $display("FAIL wdog_resp: err=%b p=%h want 1 0", resp_err, resp_product); end
    handshake();
    core_en = 1'b1;
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    issue(32'h4, 32'h5);
    repeat (4) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_run: busy=%b ready=%b want 1 0", busy, req_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || a !== 32'h0) begin bad++; $display("FAIL midrst_state: valid=%b ready=%b a=%h want 0 1 0", resp_valid, req_ready, a); end
    reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_resp: resp_valid seen %b want 0", seen); end
  endtask

  task automatic test_zero();
    int lat; bit sr; bit am; int s0;
    s0 = start_cnt;
    issue(32'h0, 32'h1234);
    wait_resp(1, lat, sr, am);
`ifdef MULT_IF_ZERO_BYPASS_EN
    total++; if (lat !== 1 || start_cnt - s0 !== 0) begin bad++; $display("FAIL zero_bypass: lat=%0d starts=%0d want 1 0", lat, start_cnt - s0); end
`else
    total++; if (lat !== 11 || start_cnt - s0 !== 1) begin bad++; $display("FAIL zero_core: lat=%0d starts=%0d want 11 1", lat, start_cnt - s0); end
`endif
    total++; if (resp_product !== 64'h0 || resp_err !== 1'b0) begin bad++; $display("FAIL zero_resp: p=%h err=%b want 0 0", resp_product, resp_err); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_large();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_op();
    test_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
